// File: rtl/norm_pack.sv
// Normalizes an unpacked sign/exponent/significand and packs it into IEEE-754 single; NORM_PACK_RNE_EN selects round-to-nearest-even, otherwise truncation.
// Latency: 3 cycles from accept to out_valid for a normalized operand, plus one cycle per NORM shift step.
// Backpressure: one operand in flight; in_ready only in IDLE, result held in OUT until out_ready.
module norm_pack #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [24:0]      in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_LO  = EXP_W'(-25);
    localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'(255);

    state_t                  r_state, w_state_nxt;
    logic                    r_sign, w_sign_nxt;
    logic signed [EXP_W-1:0] r_exp, w_exp_nxt;
    logic [24:0]             r_sig, w_sig_nxt;
    logic                    r_guard, w_guard_nxt;
    logic                    r_sticky, w_sticky_nxt;
    logic                    r_nz, w_nz_nxt;
    logic [31:0]             r_result, w_result_nxt;
    logic                    r_ovf, w_ovf_nxt;
    logic                    r_udf, w_udf_nxt;

    logic [24:0]             w_rsig;
    logic signed [EXP_W-1:0] w_rexp;
    logic [7:0]              w_fld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_sig    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_nz     <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_sign   <= w_sign_nxt;
            r_exp    <= w_exp_nxt;
            r_sig    <= w_sig_nxt;
            r_guard  <= w_guard_nxt;
            r_sticky <= w_sticky_nxt;
            r_nz     <= w_nz_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
            r_udf    <= w_udf_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sign_nxt   = r_sign;
        w_exp_nxt    = r_exp;
        w_sig_nxt    = r_sig;
        w_guard_nxt  = r_guard;
        w_sticky_nxt = r_sticky;
        w_nz_nxt     = r_nz;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_udf_nxt    = r_udf;

        // Rounded view of the current operand; r_sig[24] is always clear on entry to ROUND
        w_rsig = r_sig;
`ifdef NORM_PACK_RNE_EN
        if (r_guard && (r_sticky || r_sig[0])) begin
            w_rsig = r_sig + 25'd1;
        end
`endif
        w_rexp = r_exp;
        if (w_rsig[24]) begin
            w_rsig = {1'b0, w_rsig[24:1]};
            w_rexp = r_exp + EXP_ONE;
        end
        w_fld = w_rsig[23] ? w_rexp[7:0] : 8'h00;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_sign_nxt   = in_sign;
                    w_exp_nxt    = in_exp;
                    w_sig_nxt    = in_sig;
                    w_guard_nxt  = 1'b0;
                    w_sticky_nxt = 1'b0;
                    w_nz_nxt     = |in_sig;
                    w_state_nxt  = S_NORM;
                end
            end
            S_NORM: begin
                if (r_sig == 25'd0) begin
                    w_exp_nxt   = EXP_ONE;
                    w_state_nxt = S_ROUND;
                end else if (r_sig[24] || (r_exp < EXP_ONE && r_exp >= EXP_LO)) begin
                    w_sig_nxt    = {1'b0, r_sig[24:1]};
                    w_guard_nxt  = r_sig[0];
                    w_sticky_nxt = r_sticky | r_guard;
                    w_exp_nxt    = r_exp + EXP_ONE;
                end else if (r_exp < EXP_LO) begin
                    // Far below the subnormal range: everything collapses into sticky
                    w_sticky_nxt = r_sticky | (|r_sig);
                    w_sig_nxt    = '0;
                    w_exp_nxt    = EXP_ONE;
                end else if (!r_sig[23] && r_exp > EXP_ONE) begin
                    w_sig_nxt = {r_sig[23:0], 1'b0};
                    w_exp_nxt = r_exp - EXP_ONE;
                end else begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_sig_nxt    = w_rsig;
                w_exp_nxt    = w_rexp;
                w_guard_nxt  = 1'b0;
                w_sticky_nxt = 1'b0;
                if (w_rexp >= EXP_MAX) begin
                    w_result_nxt = {r_sign, 8'hFF, 23'h0};
                    w_ovf_nxt    = 1'b1;
                    w_udf_nxt    = 1'b0;
                end else begin
                    w_result_nxt = {r_sign, w_fld, w_rsig[22:0]};
                    w_ovf_nxt    = 1'b0;
                    w_udf_nxt    = (w_fld == 8'h00) && r_nz;
                end
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_OUT);
    assign out_result    = r_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_udf;

endmodule

// File: tb/tb_norm_pack.sv
// Directed bench for norm_pack: hand-computed packing results, latencies, stall and reset behaviour.
module tb_norm_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [24:0] in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int tests = 0;
    int fails = 0;

`ifdef NORM_PACK_RNE_EN
    localparam logic [31:0] ROUND_EXP = 32'h40000002;
`else
    localparam logic [31:0] ROUND_EXP = 32'h40000001;
`endif

    norm_pack #(.EXP_W(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_sig        (in_sig),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operand and measures cycles until out_valid; completes the handshake if out_ready is high
    task automatic send(input logic s, input logic [9:0] e, input logic [24:0] g,
                        output int lat, output logic [31:0] res, output logic ovf, output logic udf);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = g;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1; res = '0; ovf = 1'b0; udf = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n; res = out_result; ovf = out_overflow; udf = out_underflow;
                break;
            end
        end
        if (out_ready && lat > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0; out_ready = 1'b1;
        #23;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0 ||
            out_overflow !== 1'b0 || out_underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h ovf=%b udf=%b, want 1 0 00000000 0 0",
                     in_ready, out_valid, out_result, out_overflow, out_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normalized;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b0, 10'd127, 25'h0800000, lat, res, ovf, udf);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL norm_latency: got %0d want 3", lat); end
        tests++;
        if (res !== 32'h3F800000 || ovf !== 1'b0 || udf !== 1'b0) begin
            fails++; $display("FAIL norm_result: got %h ovf=%b udf=%b want 3f800000 0 0", res, ovf, udf);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL norm_return_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry_in;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b0, 10'd128, 25'h1000000, lat, res, ovf, udf);
        tests++;
        if (lat !== 4 || res !== 32'h40800000) begin
            fails++; $display("FAIL carry_in: got lat=%0d res=%h want 4 40800000", lat, res);
        end
    endtask

    task automatic test_left_shift;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b0, 10'd130, 25'h0000001, lat, res, ovf, udf);
        tests++;
        if (lat !== 26 || res !== 32'h35800000 || ovf !== 1'b0 || udf !== 1'b0) begin
            fails++; $display("FAIL left_shift: got lat=%0d res=%h ovf=%b udf=%b want 26 35800000 0 0", lat, res, ovf, udf);
        end
    endtask

    task automatic test_underflow;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b0, 10'h3FE, 25'h0800000, lat, res, ovf, udf);
        tests++;
        if (lat !== 6 || res !== 32'h00100000 || udf !== 1'b1 || ovf !== 1'b0) begin
            fails++; $display("FAIL underflow: got lat=%0d res=%h ovf=%b udf=%b want 6 00100000 0 1", lat, res, ovf, udf);
        end
        // -30 flushes straight to sticky: one flush cycle, one zero-detect cycle
        send(1'b1, 10'h3E2, 25'h0800000, lat, res, ovf, udf);
        tests++;
        if (lat !== 4 || res !== 32'h80000000 || udf !== 1'b1) begin
            fails++; $display("FAIL flush: got lat=%0d res=%h udf=%b want 4 80000000 1", lat, res, udf);
        end
    endtask

    task automatic test_overflow;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b0, 10'd255, 25'h0800000, lat, res, ovf, udf);
        tests++;
        if (lat !== 3 || res !== 32'h7F800000 || ovf !== 1'b1 || udf !== 1'b0) begin
            fails++; $display("FAIL overflow: got lat=%0d res=%h ovf=%b udf=%b want 3 7f800000 1 0", lat, res, ovf, udf);
        end
    endtask

    task automatic test_zero;
        int lat; logic [31:0] res; logic ovf, udf;
        send(1'b1, 10'd50, 25'h0, lat, res, ovf, udf);
        tests++;
        if (lat !== 3 || res !== 32'h80000000 || ovf !== 1'b0 || udf !== 1'b0) begin
            fails++; $display("FAIL zero: got lat=%0d res=%h ovf=%b udf=%b want 3 80000000 0 0", lat, res, ovf, udf);
        end
    endtask

    task automatic test_round_stall;
        int lat; logic [31:0] res; logic ovf, udf;
        out_ready = 1'b0;
        send(1'b0, 10'd127, 25'h1000003, lat, res, ovf, udf);
        tests++;
        if (lat !== 4 || res !== ROUND_EXP) begin
            fails++; $display("FAIL round: got lat=%0d res=%h want 4 %h", lat, res, ROUND_EXP);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_result !== ROUND_EXP || in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_hold%0d: valid=%b res=%h in_ready=%b want 1 %h 0",
                                  k, out_valid, out_result, in_ready, ROUND_EXP);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_sig = 25'h0800000;
        @(posedge clk);
        #1 in_exp = 10'd200; in_sig = 25'h1000000;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy: in_ready=%b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 64) begin @(negedge clk); n++; end
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000) begin
            fails++; $display("FAIL b2b_first: valid=%b res=%h want 1 3f800000", out_valid, out_result);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: in_ready=%b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 64) begin @(negedge clk); n++; end
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h64800000) begin
            fails++; $display("FAIL b2b_second: valid=%b res=%h want 1 64800000", out_valid, out_result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd130; in_sig = 25'h0000001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
            fails++; $display("FAIL abort_reset: valid=%b in_ready=%b res=%h want 0 1 00000000",
                              out_valid, in_ready, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL abort_no_result: busy/valid cycles=%0d want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_normalized;
        test_carry_in;
        test_left_shift;
        test_underflow;
        test_overflow;
        test_zero;
        test_round_stall;
        test_back_to_back;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/norm_pack.md
NORM_PACK -- requirements
Module: norm_pack

Interface
REQ-001 SHALL have parameter: EXP_W, 10, width of signed working exponent (minimum 10).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  unpacked operand present.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port: in_sign  input  1  result sign.
REQ-007 SHALL have port: in_exp  input  EXP_W  two's-complement biased exponent; value = in_sig * 2^(in_exp-150).
REQ-008 SHALL have port: in_sig  input  25  significand; bit 24 carry, bit 23 hidden position.
REQ-009 SHALL have port: out_valid  output  1  packed result present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: out_result  output  32  IEEE-754 single.
REQ-012 SHALL have port: out_overflow  output  1  result saturated to infinity.
REQ-013 SHALL have port: out_underflow  output  1  nonzero input packed with exponent field 0.

Function
REQ-014 SHALL implement FSM IDLE, NORM, ROUND, OUT; in_ready = (state==IDLE).
REQ-015 SHALL, on in_valid && in_ready, capture sign/exp/sig, clear guard and sticky, and enter NORM.
REQ-016 SHALL, in NORM, perform one action per cycle, in priority order: sig==0 -> ROUND with exp=1; sig[24] -> shift right 1, exp+1; exp < -25 -> sticky |= |sig|, sig=0, exp=1; exp<1 -> shift right 1, exp+1; !sig[23] && exp>1 -> shift left 1, exp-1; otherwise -> ROUND.
REQ-017 SHALL, on every right shift, move the bit shifted out into guard and OR the old guard into sticky; left shifts shift in 0.
REQ-018 SHALL, in ROUND, truncate (guard/sticky discarded) and then go to OUT.
REQ-019 SHALL, in ROUND, handle a carry into sig[24] by shifting right 1 and adding 1 to exp.
REQ-020 SHALL, on entering OUT, pack: exp>=255 -> {sign,8'hFF,23'h0} with out_overflow=1; else {sign, sig[23] ? exp[7:0] : 8'h00, sig[22:0]}.
REQ-021 SHALL set out_underflow=1 when the packed exponent field is 0 and the captured in_sig was nonzero.
REQ-022 SHALL hold out_valid, out_result and the flags stable in OUT until out_ready; the handshake cycle returns to IDLE.
REQ-023 SHALL have latency: accept at edge T; already-normalized operand gives out_valid at T+3; each NORM shift adds one cycle.
REQ-024 SHALL accept no new operand before the OUT handshake, and SHALL ignore in_valid outside IDLE.
REQ-025 SHALL bound NORM: at most 27 cycles per operand.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_underflow=0, and clear internal registers.
REQ-027 SHALL abort any in-flight operand on reset; no result for it is ever presented.

Configuration
REQ-028 SHALL, when NORM_PACK_RNE_EN is defined, have ROUND round to nearest-even: increment sig when guard && (sticky || sig[0]), then apply REQ-019.
REQ-029 SHALL, when NORM_PACK_RNE_EN is undefined, round toward zero per REQ-018; latency is identical in both builds.

Verification
REQ-030 SHALL cover: exp=127, sig=0x0800000, sign=0 -> out_result=0x3F800000, out_valid at T+3, flags 0.
REQ-031 SHALL cover: exp=128, sig=0x1000000 -> 0x40800000 at T+4.
REQ-032 SHALL cover: exp=130, sig=0x0000001 -> 0x35800000 after 23 left shifts, at T+26.
REQ-033 SHALL cover: exp=-2, sig=0x0800000 -> 0x00100000, out_underflow=1.
REQ-034 SHALL cover: exp=255, sig=0x0800000 -> 0x7F800000, out_overflow=1.
REQ-035 SHALL cover: exp=127, sig=0x1000003 -> 0x40000002 with NORM_PACK_RNE_EN, 0x40000001 without; out_ready held 0 for 5 cycles keeps the result stable; rst_n pulsed during NORM -> out_valid stays 0 and in_ready=1.
